// File: rtl/fifo_burst_reader.sv
// Drains fifo_ctrl through its 1-cycle-latency read port.
// Re-emits the words as a valid/ready stream framed into bursts.
module fifo_burst_reader #(
    parameter int DATA_W      = 32,
    parameter int BURST_LEN   = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               flush,
    output logic                               fifo_rd_en,
    input  logic [DATA_W-1:0]                  fifo_dout,
    input  logic                               fifo_empty,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [DATA_W-1:0]                  m_data,
    output logic                               m_last,
    output logic [$clog2(BURST_LEN+1)-1:0]     beat_idx,
    output logic [15:0]                        bursts_sent
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int IW = $clog2(TIMEOUT_CYC + 2);
    localparam logic [BW-1:0] LAST_IDX = BW'(BURST_LEN - 1);
    localparam logic [IW-1:0] TMO = IW'(TIMEOUT_CYC);
    localparam bit TMO_EN = (TIMEOUT_CYC != 0);

    logic [DATA_W-1:0] mem_q [4];
    logic [DATA_W-1:0] mem_d [4];
    logic [3:0]        mark_q, mark_d;
    logic [1:0]        head_q, head_d;
    logic [1:0]        tail_q, tail_d;
    logic [2:0]        occ_q, occ_d;
    logic              infl_q, infl_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [15:0]       sent_q, sent_d;

    logic at_last_idx;
    logic head_mark;
    logic release_ok;
    logic held;
    logic valid_c;
    logic last_c;
    logic fire;
    logic rd_c;
    logic timeout_hit;
    logic flush_hit;

    // mark_q tags the word that closes a partial burst; it rides with the data
    always_comb begin
        at_last_idx = (beat_q == LAST_IDX);
        head_mark   = mark_q[head_q];
        release_ok  = at_last_idx || (occ_q >= 3'd2) || infl_q || head_mark;
        valid_c     = (occ_q != 3'd0) && release_ok;
        held        = (occ_q != 3'd0) && !release_ok;
        last_c      = valid_c && (at_last_idx || head_mark);
        fire        = valid_c && m_ready;
        rd_c        = en && !fifo_empty
                      && ((occ_q + {2'b00, infl_q}) < 3'd4);
        timeout_hit = TMO_EN && held && (idle_q == TMO);
        flush_hit   = flush && !infl_q && (occ_q != 3'd0);
    end

    always_comb begin
        mem_d  = mem_q;
        mark_d = mark_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q + {2'b00, infl_q} - {2'b00, fire};
        infl_d = rd_c;
        idle_d = '0;
        beat_d = beat_q;
        sent_d = sent_q;

        if (fire) begin
            head_d = head_q + 2'd1;
            if (last_c) begin
                beat_d = '0;
                sent_d = sent_q + 16'd1;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end

        if (flush_hit) begin
            mark_d[tail_q - 2'd1] = 1'b1;
        end
        if (timeout_hit) begin
            mark_d[head_q] = 1'b1;
        end

        // A flush while a read is in flight tags the word that lands now
        if (infl_q) begin
            mem_d[tail_q]  = fifo_dout;
            mark_d[tail_q] = flush;
            tail_d         = tail_q + 2'd1;
        end

        if (held && fifo_empty) begin
            idle_d = (idle_q == TMO) ? idle_q : idle_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            mark_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            infl_q <= 1'b0;
            idle_q <= '0;
            beat_q <= '0;
            sent_q <= '0;
        end else begin
            mem_q  <= mem_d;
            mark_q <= mark_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            infl_q <= infl_d;
            idle_q <= idle_d;
            beat_q <= beat_d;
            sent_q <= sent_d;
        end
    end

    always_comb begin
        fifo_rd_en  = rd_c;
        m_valid     = valid_c;
        m_last      = last_c;
        m_data      = valid_c ? mem_q[head_q] : '0;
        beat_idx    = beat_q;
        bursts_sent = sent_q;
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO models with 1-cycle read latency,
// a beat monitor and scenario tasks checked against burst-framing rules.
module tb_fifo_burst_reader;

    localparam int DW  = 32;
    localparam int BL  = 4;
    localparam int TMO = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [2:0]    idx;
        int            c;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          en0, flush0, rd0, empty0, mv0, mr0, ml0;
    logic [DW-1:0] dout0, md0;
    logic [2:0]    bi0;
    logic [15:0]   bs0;

    logic          en1, flush1, rd1, empty1, mv1, mr1, ml1;
    logic [DW-1:0] dout1, md1;
    logic [2:0]    bi1;
    logic [15:0]   bs1;

    fifo_burst_reader #(.DATA_W(DW), .BURST_LEN(BL), .TIMEOUT_CYC(TMO)) u_dut0 (
        .clk(clk), .rst(rst), .en(en0), .flush(flush0),
        .fifo_rd_en(rd0), .fifo_dout(dout0), .fifo_empty(empty0),
        .m_valid(mv0), .m_ready(mr0), .m_data(md0), .m_last(ml0),
        .beat_idx(bi0), .bursts_sent(bs0)
    );

    fifo_burst_reader #(.DATA_W(DW), .BURST_LEN(BL), .TIMEOUT_CYC(0)) u_dut1 (
        .clk(clk), .rst(rst), .en(en1), .flush(flush1),
        .fifo_rd_en(rd1), .fifo_dout(dout1), .fifo_empty(empty1),
        .m_valid(mv1), .m_ready(mr1), .m_data(md1), .m_last(ml1),
        .beat_idx(bi1), .bursts_sent(bs1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] src0[$], pend0[$], src1[$], pend1[$];
    beat_t         obs0[$], obs1[$];
    int            stab_err0 = 0;
    int            rdemp_err0 = 0;
    int            rdemp_err1 = 0;
    logic          pv0;
    logic [DW-1:0] pd0;
    logic          pl0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO models: pushes from tasks land on the next edge
    always @(posedge clk) begin
        if (rst) begin
            src0.delete();
            pend0.delete();
            empty0 <= 1'b1;
            dout0  <= '0;
        end else begin
            if (rd0 && src0.size() != 0) dout0 <= src0.pop_front();
            while (pend0.size() != 0) src0.push_back(pend0.pop_front());
            empty0 <= (src0.size() == 0);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            src1.delete();
            pend1.delete();
            empty1 <= 1'b1;
            dout1  <= '0;
        end else begin
            if (rd1 && src1.size() != 0) dout1 <= src1.pop_front();
            while (pend1.size() != 0) src1.push_back(pend1.pop_front());
            empty1 <= (src1.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pv0 = 1'b0;
        end else begin
            if (pv0 && (!mv0 || md0 !== pd0 || ml0 !== pl0)) stab_err0++;
            if (rd0 && empty0) rdemp_err0++;
            if (mv0 && mr0) obs0.push_back('{md0, ml0, bi0, cyc});
            pv0 = mv0 && !mr0;
            pd0 = md0;
            pl0 = ml0;
            if (rd1 && empty1) rdemp_err1++;
            if (mv1 && mr1) obs1.push_back('{md1, ml1, bi1, cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        en0 = 1'b1; flush0 = 1'b0; mr0 = 1'b1;
        en1 = 1'b1; flush1 = 1'b0; mr1 = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({rd0, mv0, ml0} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=000", {rd0, mv0, ml0});
        end
        total++;
        if (md0 !== '0 || bi0 !== '0 || bs0 !== '0) begin
            bad++;
            $display("FAIL reset_val got=%h/%0d/%0d want=0/0/0", md0, bi0, bs0);
        end
        total++;
        if ({rd1, mv1, ml1} !== 3'b000 || bs1 !== '0) begin
            bad++;
            $display("FAIL reset_dut1 got=%b/%0d want=000/0", {rd1, mv1, ml1}, bs1);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_bursts();
        logic [15:0] base;
        obs0.delete();
        base = bs0;
        mr0 = 1'b1;
        for (int k = 0; k < 8; k++) pend0.push_back(32'h10 + 32'(k));
        for (int i = 0; i < 100 && obs0.size() < 8; i++) tick();
        tick();
        total++;
        if (obs0.size() != 8) begin
            bad++;
            $display("FAIL full_count got=%0d want=8", obs0.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++;
                if (obs0[k].d !== 32'h10 + 32'(k) || obs0[k].l !== (k % BL == BL - 1)
                    || obs0[k].idx !== 3'(k % BL)) begin
                    bad++;
                    $display("FAIL full_beat%0d got=%h/%b/%0d want=%h/%b/%0d", k,
                             obs0[k].d, obs0[k].l, obs0[k].idx,
                             32'h10 + 32'(k), (k % BL == BL - 1), k % BL);
                end
            end
            for (int k = 1; k < 8; k++) begin
                total++;
                if (obs0[k].c - obs0[k-1].c != 1) begin
                    bad++;
                    $display("FAIL full_bubble%0d got=%0d want=1", k, obs0[k].c - obs0[k-1].c);
                end
            end
        end
        total++;
        if (bs0 !== base + 16'd2) begin
            bad++;
            $display("FAIL full_bursts got=%0d want=%0d", bs0, base + 16'd2);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] base;
        int          cnt;
        obs0.delete();
        base = bs0;
        mr0 = 1'b1;
        for (int k = 0; k < 3; k++) pend0.push_back(32'hA0 + 32'(k));
        for (int i = 0; i < 100 && obs0.size() < 2; i++) tick();
        total++;
        if (obs0.size() != 2 || obs0[0].l !== 1'b0 || obs0[1].l !== 1'b0) begin
            bad++;
            $display("FAIL tmo_first got=%0d beats want=2 non-last", obs0.size());
        end
        cnt = 0;
        while (!mv0 && cnt < 100) begin
            cnt++;
            tick();
        end
        total++;
        if (cnt != TMO + 1) begin
            bad++;
            $display("FAIL tmo_delay got=%0d want=%0d", cnt, TMO + 1);
        end
        total++;
        if (md0 !== 32'hA2 || ml0 !== 1'b1 || bi0 !== 3'd2) begin
            bad++;
            $display("FAIL tmo_beat got=%h/%b/%0d want=a2/1/2", md0, ml0, bi0);
        end
        tick();
        total++;
        if (bi0 !== 3'd0 || bs0 !== base + 16'd1 || obs0.size() != 3) begin
            bad++;
            $display("FAIL tmo_after got=%0d/%0d/%0d want=0/%0d/3", bi0, bs0, obs0.size(),
                     base + 16'd1);
        end
    endtask

    task automatic test_flush();
        logic [15:0] base;
        obs0.delete();
        base = bs0;
        mr0 = 1'b1;
        pend0.push_back(32'h55);
        repeat (4) tick();
        total++;
        if (mv0 !== 1'b0) begin
            bad++;
            $display("FAIL flush_held got=%b want=0", mv0);
        end
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        total++;
        if (mv0 !== 1'b1 || ml0 !== 1'b1 || md0 !== 32'h55) begin
            bad++;
            $display("FAIL flush_release got=%b/%b/%h want=1/1/55", mv0, ml0, md0);
        end
        tick();
        total++;
        if (bs0 !== base + 16'd1 || bi0 !== 3'd0) begin
            bad++;
            $display("FAIL flush_after got=%0d/%0d want=%0d/0", bs0, bi0, base + 16'd1);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0]   base;
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] w;
        obs0.delete();
        base = bs0;
        stab_err0 = 0;
        rdemp_err0 = 0;
        for (int k = 0; k < 100; k++) begin
            w = $urandom;
            exp_q.push_back(w);
            pend0.push_back(w);
        end
        for (int i = 0; i < 3000 && obs0.size() < 100; i++) begin
            mr0 = 1'($urandom_range(0, 1));
            tick();
        end
        mr0 = 1'b1;
        tick();
        total++;
        if (obs0.size() != 100) begin
            bad++;
            $display("FAIL bp_count got=%0d want=100", obs0.size());
        end else begin
            for (int k = 0; k < 100; k++) begin
                total++;
                if (obs0[k].d !== exp_q[k] || obs0[k].l !== (k % BL == BL - 1)
                    || obs0[k].idx !== 3'(k % BL)) begin
                    bad++;
                    $display("FAIL bp_beat%0d got=%h/%b/%0d want=%h/%b/%0d", k,
                             obs0[k].d, obs0[k].l, obs0[k].idx,
                             exp_q[k], (k % BL == BL - 1), k % BL);
                end
            end
        end
        total++;
        if (stab_err0 != 0) begin
            bad++;
            $display("FAIL bp_stable got=%0d want=0", stab_err0);
        end
        total++;
        if (rdemp_err0 != 0) begin
            bad++;
            $display("FAIL bp_rd_empty got=%0d want=0", rdemp_err0);
        end
        total++;
        if (bs0 !== base + 16'd25) begin
            bad++;
            $display("FAIL bp_bursts got=%0d want=%0d", bs0, base + 16'd25);
        end
    endtask

    task automatic test_timeout_disabled();
        int vcnt;
        obs1.delete();
        mr1 = 1'b1;
        for (int k = 0; k < 5; k++) pend1.push_back(32'hB0 + 32'(k));
        for (int i = 0; i < 100 && obs1.size() < 4; i++) tick();
        vcnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (mv1) vcnt++;
        end
        total++;
        if (obs1.size() != 4 || vcnt != 0 || bs1 !== 16'd1) begin
            bad++;
            $display("FAIL nto_hold got=%0d/%0d/%0d want=4/0/1", obs1.size(), vcnt, bs1);
        end
        for (int k = 5; k < 8; k++) pend1.push_back(32'hB0 + 32'(k));
        for (int i = 0; i < 100 && obs1.size() < 8; i++) tick();
        tick();
        total++;
        if (obs1.size() != 8) begin
            bad++;
            $display("FAIL nto_count got=%0d want=8", obs1.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++;
                if (obs1[k].d !== 32'hB0 + 32'(k) || obs1[k].l !== (k % BL == BL - 1)) begin
                    bad++;
                    $display("FAIL nto_beat%0d got=%h/%b want=%h/%b", k, obs1[k].d,
                             obs1[k].l, 32'hB0 + 32'(k), (k % BL == BL - 1));
                end
            end
        end
        total++;
        if (bs1 !== 16'd2 || rdemp_err1 != 0) begin
            bad++;
            $display("FAIL nto_bursts got=%0d/%0d want=2/0", bs1, rdemp_err1);
        end
    endtask

    task automatic test_reset_mid_burst();
        obs0.delete();
        mr0 = 1'b1;
        for (int k = 0; k < 8; k++) pend0.push_back(32'h60 + 32'(k));
        for (int i = 0; i < 100 && obs0.size() < 2; i++) tick();
        rst = 1'b1;
        tick();
        total++;
        if ({rd0, mv0, ml0} !== 3'b000 || md0 !== '0 || bi0 !== '0 || bs0 !== '0) begin
            bad++;
            $display("FAIL midrst_out got=%b/%h/%0d/%0d want=000/0/0/0",
                     {rd0, mv0, ml0}, md0, bi0, bs0);
        end
        rst = 1'b0;
        obs0.delete();
        for (int k = 0; k < 4; k++) pend0.push_back(32'h70 + 32'(k));
        for (int i = 0; i < 100 && obs0.size() < 4; i++) tick();
        tick();
        total++;
        if (obs0.size() != 4) begin
            bad++;
            $display("FAIL midrst_count got=%0d want=4", obs0.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (obs0[k].d !== 32'h70 + 32'(k) || obs0[k].idx !== 3'(k)
                    || obs0[k].l !== (k == 3)) begin
                    bad++;
                    $display("FAIL midrst_beat%0d got=%h/%0d/%b want=%h/%0d/%b", k,
                             obs0[k].d, obs0[k].idx, obs0[k].l, 32'h70 + 32'(k), k, (k == 3));
                end
            end
        end
        total++;
        if (bs0 !== 16'd1) begin
            bad++;
            $display("FAIL midrst_bursts got=%0d want=1", bs0);
        end
    endtask

    initial begin
        test_reset();
        test_full_bursts();
        test_timeout();
        test_flush();
        test_backpressure();
        test_timeout_disabled();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Drain stage that sits directly downstream of `fifo_ctrl`. It pops words through the FIFO's `rd_en`/`dout` port, which has 1-cycle read latency. It re-emits the words as a valid/ready stream framed into bursts of `BURST_LEN` beats, with `m_last` on the final beat. Partial bursts are closed by an idle timeout or an explicit `flush`, so a quiet FIFO never strands data.

## Interface
- `DATA_W`, 32: data width; matches `fifo_ctrl` `DATA_W`.
- `BURST_LEN`, 16: beats per full burst; must be ≥ 1.
- `TIMEOUT_CYC`, 64: idle cycles before a partial burst is closed; 0 disables the timeout.

- `clk` in 1: the only clock.
- `rst` in 1: reset; synchronous, active-high.
- `en` in 1: allows new FIFO reads.
- `flush` in 1: single-cycle pulse that closes the current partial burst.
- `fifo_rd_en` out 1: drives `fifo_ctrl.rd_en`.
- `fifo_dout` in `DATA_W`: from `fifo_ctrl.dout`; valid the cycle after `fifo_rd_en`.
- `fifo_empty` in 1: from `fifo_ctrl.empty`.
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: downstream accept.
- `m_data` out `DATA_W`: output beat data.
- `m_last` out 1: final beat of a burst.
- `beat_idx` out `$clog2(BURST_LEN+1)`: index of the current beat within its burst.
- `bursts_sent` out 16: count of completed bursts; wraps.

## Operation
- **Internal buffer**
  - 4-entry in-order skid buffer.
  - `occ` = entries held; `infl` = reads issued whose data has not yet landed (0 or 1).
- **FIFO reads**
  - `fifo_rd_en = en && !fifo_empty && (occ + infl) < 4`.
  - Computed from registered state and `fifo_empty` only; there is no path from `m_ready`.
  - Never asserted while `fifo_empty` is high.
- **Capture:** the cycle after `fifo_rd_en`, `fifo_dout` is written at the buffer tail.
- **Handshake:** a beat transfers when `m_valid && m_ready`. On transfer, the head is popped and `beat_idx` increments.
  - If `m_last` was set: `beat_idx` returns to 0 and `bursts_sent` increments.
- **Head release.** The head is presented (`m_valid=1`) when any of these holds:
  - (a) `beat_idx == BURST_LEN-1`, so `m_last=1`;
  - (b) `occ ≥ 2` or `infl == 1`, so `m_last=0`;
  - (c) the `close` flag is set, so `m_last=1`.
- **Held state.** The head is held (`m_valid=0`) otherwise, i.e. when it is the only known word and its last-ness is still undecided.
- **Close flag**
  - Set when, in the held state, `idle_cnt == TIMEOUT_CYC` with `TIMEOUT_CYC ≠ 0`.
  - Also set when `flush` is asserted with `occ ≥ 1`.
  - `flush` with `occ == 0` and `infl == 0` is ignored.
  - With `infl == 1`, `flush` is remembered and applies to the newest word once it lands; older words are released as non-last.
  - The flag stays set until the last beat transfers, then clears.
- **Idle counter:** `idle_cnt` increments every cycle in the held state with `fifo_empty=1`. It resets to 0 on any cycle where the held state is false or `fifo_empty=0`.
- **Protocol rules**
  - Once `m_valid=1`, `m_data`, `m_last` and `m_valid` stay stable until the transfer.
  - New arrivals never revoke an asserted `m_last`. Words arriving after `close` is set start the next burst.
- **Disabling:** when `en=0`, no reads are issued. Buffered words drain under the same release rules.
- **Reset**
  - Buffer, `infl`, `close`, `idle_cnt`, `beat_idx` and `bursts_sent` clear.
  - Any word in flight is discarded. `fifo_ctrl` shares `rst`, so it is reset on the same edge.

## Timing
- **Reset values:** `fifo_rd_en=0`, `m_valid=0`, `m_data=0`, `m_last=0`, `beat_idx=0`, `bursts_sent=0`.
- **Latency**
  - First word into an empty FIFO: `fifo_rd_en` at T, capture at T+1. The earliest `m_valid` is at T+2 when (a) or (b) holds.
  - With `BURST_LEN=1`, every beat is presented at T+2.
- **Throughput:** 1 beat/cycle sustained while the FIFO is non-empty and `m_ready=1`.
- **Timeout release:** `m_valid` rises exactly `TIMEOUT_CYC+1` cycles after the held state with `fifo_empty=1` begins.
- **Flush release:** `m_valid` with `m_last=1` appears the cycle after a `flush` that is applied to the held head.
- **Combinational paths:** `m_valid` and `m_last` have no combinational path from `m_ready`.

## Test plan
- **Full bursts:** `BURST_LEN=4`; push 0x10..0x17 with `m_ready=1` → two back-to-back 4-beat bursts; `m_last` on 0x13 and 0x17; `bursts_sent=2`; no bubbles after the first beat.
- **Timeout close:** `TIMEOUT_CYC=8`; push 0xA0..0xA2 → 0xA0 and 0xA1 sent with `m_last=0`; 0xA2 held for 8 idle cycles, then sent with `m_last=1`; `beat_idx` returns to 0.
- **Backpressure:** push 100 random words with `m_ready` 50% random → order preserved; data stable during stalls; `fifo_rd_en` never asserted while empty; `m_last` every 4th beat.
- **Flush:** single held word 0x55, pulse `flush` → next cycle `m_valid=1`, `m_last=1`, `m_data=0x55`.
- **Timeout disabled:** `TIMEOUT_CYC=0`; push 5 words → 4 sent, 5th held for 1000 cycles; push 3 more → burst completes with `m_last` on the 8th word.
- **Reset mid-burst:** assert `rst` after beat 2 → all outputs 0 the next cycle; after release, new data starts at `beat_idx=0`.
